udiv_laccp_sched: RTL and testbench
===================================

// Module: udiv_laccp_sched
// PURPOSE
//  Shares one udiv_laccp_q fixed-point divider core between NCH requesters.
//  - Each channel owns a one-entry operand slot.
//  - A round-robin scheduler launches one division at a time on the core.
//  - Results return on a single response bus, tagged with the channel id, under valid/ready.
//  - Sits between LACCP timing/rate-estimation clients and the divider core.
// PARAMETERS
//  NCH  4   number of requester channels (>=2)
//  DW   16  operand width, passed to core
//  QI   16  quotient integer bits, passed to core
//  QF   8   quotient fraction bits, passed to core
//  CHW  localparam = $clog2(NCH); width of channel id
// PORTS
//  clk          in   1        clock
//  rst          in   1        reset, synchronous, active-high
//  req_valid    in   NCH      per-channel request strobe
//  req_ready    out  NCH      per-channel slot empty
//  req_dividend in   NCH*DW   packed dividends, channel i at [i*DW +: DW]
//  req_divisor  in   NCH*DW   packed divisors, same packing
//  rsp_valid    out  1        result held on response bus
//  rsp_ready    in   1        consumer accepts result
//  rsp_ch       out  CHW      channel id of the result
//  rsp_q_int    out  QI       quotient, integer part
//  rsp_q_frac   out  QF       quotient, fraction part (truncated)
//  rsp_dbz      out  1        divisor was zero; the q fields are 0
//  sched_busy   out  1        any slot pending, or FSM not in IDLE
// BEHAVIOUR
//  Reset
//  - All slots empty; req_ready all 1; rsp_* all 0.
//  - FSM = IDLE; RR pointer = 0; core reset.
//  - rst mid-operation discards pending slots and the in-flight division. No response is emitted.
//  Slot handshake
//  - A request is accepted when req_valid[i] & req_ready[i]; operands are latched at that edge.
//  - req_ready[i] drops the next cycle.
//  - req_ready[i] returns 1 the cycle after the slot's response is accepted (rsp_valid & rsp_ready).
//  Arbitration
//  - Pending slots are searched starting at (last_grant+1) mod NCH; the first pending slot wins.
//  - Last_grant is updated on launch.
//  - A channel re-requesting immediately cannot win twice while another channel is pending.
//  FSM
//  - IDLE -> LAUNCH: when any slot is pending.
//  - LAUNCH: pulse core start for 1 cycle with the winner's operands; record the winner id. -> WAIT.
//  - WAIT: hold until core valid. Then latch q_int, q_frac, div_by_zero and id into rsp_*, and set rsp_valid. -> RESP.
//  - RESP: hold rsp_* stable while rsp_valid & !rsp_ready.
//  - On acceptance, free that slot; -> LAUNCH if another slot is pending, else -> IDLE.
//  Timing
//  - Grant-to-rsp_valid = 1 (LAUNCH) + core latency.
//  - Core launches are never overlapped; start is only issued while the core is not busy.
//  - Back-to-back throughput is one result per (core latency + 2) cycles with rsp_ready tied high.
//  Simultaneous events
//  - A new request on channel i in the same cycle as its slot is freed is not accepted.
//  - req_ready[i] is still 0 in that cycle.
//  - Requests arriving on other channels during WAIT/RESP are latched and queued.
// CONFIGURATION
//  UDIV_SCHED_STATS_EN
//  - Defined: adds output stat_done (NCH*16), a per-channel count of accepted responses.
//  - Also adds output stat_dbz (16), the total count of divide-by-zero results.
//  - Both counters saturate at 16'hFFFF and are cleared by rst.
//  - Not defined: these ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  - Shared package udiv_laccp_pkg: FSM state enum (IDLE, LAUNCH, WAIT, RESP), STAT_W=16, and the round-robin next-index function.
//  - Sub-module: one udiv_laccp_q instance, with DW, QI and QF passed through.
//  - The scheduler drives start, dividend and divisor; it consumes valid, div_by_zero, q_int and q_frac.
// TESTING
//  1. Single request: ch0 100/7 -> rsp_ch=0, q_int=14, q_frac=73, rsp_dbz=0; req_ready[0] high again after acceptance.
//  2. Divide by zero: ch2 55/0 -> rsp_ch=2, rsp_dbz=1, q_int=0, q_frac=0; same latency as a normal op.
//  3. All 4 channels request in the same cycle (ops 1/1, 2/1, 3/1, 4/1) -> responses in order ch0,1,2,3 with q_int 1,2,3,4.
//  4. Fairness: ch0 re-requests every time it is freed while ch3 is pending -> ch3 is served before ch0's second op.
//  5. Backpressure: hold rsp_ready=0 for 20 cycles -> rsp_* stable and no new launch; after release, the next op launches.
//  6. Assert rst during WAIT -> all outputs at reset values next cycle and no stale rsp_valid; 9/3 afterwards gives q_int=3.

Source files
------------

// File: rtl/udiv_laccp_pkg.sv
// Shared types for the udiv_laccp divider scheduler.
// FSM states, statistics counter width and round-robin helper.
package udiv_laccp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_t;

  localparam int STAT_W = 16;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/udiv_laccp_q.sv
// Iterative fixed-point divider: q = (dividend << QF) / divisor.
// One quotient bit per cycle; a zero divisor flags div_by_zero with q = 0.
module udiv_laccp_q #(
  parameter int DW = 16,
  parameter int QI = 16,
  parameter int QF = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          valid,
  output logic          div_by_zero,
  output logic [QI-1:0] q_int,
  output logic [QF-1:0] q_frac
);

  localparam int NW = DW + QF;
  localparam int CW = $clog2(NW + 1);

  logic [NW-1:0]    num;
  logic [NW-1:0]    quo;
  logic [DW-1:0]    den;
  logic [DW-1:0]    rem;
  logic [CW-1:0]    cnt;
  logic             dbz;
  logic [DW:0]      rsh;
  logic [DW:0]      rdiff;
  logic             qbit;
  logic [QI+QF-1:0] qx;

  // restoring-division step on the current partial remainder
  always_comb begin
    rsh   = {rem, num[NW-1]};
    rdiff = rsh - {1'b0, den};
    qbit  = (rsh >= {1'b0, den});
    qx    = (QI+QF)'({quo[NW-2:0], qbit});
  end

  // operand load, bit iteration and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      valid       <= 1'b0;
      div_by_zero <= 1'b0;
      q_int       <= '0;
      q_frac      <= '0;
      num         <= '0;
      quo         <= '0;
      den         <= '0;
      rem         <= '0;
      cnt         <= '0;
      dbz         <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start && !busy) begin
        num  <= {dividend, {QF{1'b0}}};
        quo  <= '0;
        rem  <= '0;
        den  <= divisor;
        dbz  <= (divisor == '0);
        cnt  <= CW'(NW);
        busy <= 1'b1;
      end else if (busy) begin
        rem <= qbit ? rdiff[DW-1:0] : rsh[DW-1:0];
        num <= num << 1;
        quo <= {quo[NW-2:0], qbit};
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy        <= 1'b0;
          valid       <= 1'b1;
          div_by_zero <= dbz;
          q_int       <= dbz ? '0 : qx[QF +: QI];
          q_frac      <= dbz ? '0 : qx[0 +: QF];
        end
      end
    end
  end

endmodule

// File: rtl/udiv_laccp_sched.sv
// Round-robin scheduler sharing one udiv_laccp_q core among NCH channels.
// Optional UDIV_SCHED_STATS_EN adds per-channel done and divide-by-zero counters.
module udiv_laccp_sched
  import udiv_laccp_pkg::*;
#(
  parameter  int NCH = 4,
  parameter  int DW  = 16,
  parameter  int QI  = 16,
  parameter  int QF  = 8,
  localparam int CHW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req_valid,
  output logic [NCH-1:0]    req_ready,
  input  logic [NCH*DW-1:0] req_dividend,
  input  logic [NCH*DW-1:0] req_divisor,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [CHW-1:0]    rsp_ch,
  output logic [QI-1:0]     rsp_q_int,
  output logic [QF-1:0]     rsp_q_frac,
  output logic              rsp_dbz,
`ifdef UDIV_SCHED_STATS_EN
  output logic [NCH*STAT_W-1:0] stat_done,
  output logic [STAT_W-1:0]     stat_dbz,
`endif
  output logic              sched_busy
);

  state_t         state;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] accept;
  logic [NCH-1:0] freed;
  logic [NCH-1:0] avail;
  logic [DW-1:0]  sa [NCH];
  logic [DW-1:0]  sb [NCH];
  logic [CHW-1:0] ptr;
  logic [CHW-1:0] cur_ch;
  logic [CHW-1:0] win;
  logic           win_ok;
  logic           launch;
  logic           start;
  logic [DW-1:0]  ca;
  logic [DW-1:0]  cb;
  logic           c_busy;
  logic           c_valid;
  logic           c_dbz;
  logic [QI-1:0]  c_qi;
  logic [QF-1:0]  c_qf;

  assign req_ready  = ~pend;
  assign accept     = req_valid & ~pend;
  assign sched_busy = (|pend) || (state != IDLE);

  // pick the first pending slot at or after ptr, skipping one being freed
  always_comb begin
    int idx;
    freed  = '0;
    if (state == RESP && rsp_ready)
      freed[cur_ch] = 1'b1;
    avail  = pend & ~freed;
    win    = '0;
    win_ok = 1'b0;
    idx    = int'(ptr);
    for (int k = 0; k < NCH; k++) begin
      if (!win_ok && avail[idx]) begin
        win    = CHW'(idx);
        win_ok = 1'b1;
      end
      idx = rr_next(idx, NCH);
    end
    launch = win_ok &&
             (state == IDLE || (state == RESP && rsp_ready));
  end

  // slot occupancy: set on accept, cleared when its response is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (accept[i])
          pend[i] <= 1'b1;
        else if (freed[i])
          pend[i] <= 1'b0;
      end
    end
  end

  // operand capture into the per-channel slots
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (accept[i]) begin
        sa[i] <= req_dividend[i*DW +: DW];
        sb[i] <= req_divisor[i*DW +: DW];
      end
    end
  end

  // scheduler FSM with registered start pulse and response bus
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cur_ch     <= '0;
      start      <= 1'b0;
      ca         <= '0;
      cb         <= '0;
      rsp_valid  <= 1'b0;
      rsp_ch     <= '0;
      rsp_q_int  <= '0;
      rsp_q_frac <= '0;
      rsp_dbz    <= 1'b0;
    end else begin
      start <= 1'b0;
      unique case (state)
        IDLE:   state <= IDLE;
        LAUNCH: state <= WAIT;
        WAIT: begin
          if (c_valid) begin
            rsp_valid  <= 1'b1;
            rsp_ch     <= cur_ch;
            rsp_q_int  <= c_qi;
            rsp_q_frac <= c_qf;
            rsp_dbz    <= c_dbz;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (launch) begin
        state  <= LAUNCH;
        start  <= 1'b1;
        cur_ch <= win;
        ca     <= sa[win];
        cb     <= sb[win];
        ptr    <= CHW'(rr_next(int'(win), NCH));
      end
    end
  end

`ifdef UDIV_SCHED_STATS_EN
  // saturating counts of accepted responses and divide-by-zero results
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_done <= '0;
      stat_dbz  <= '0;
    end else if (rsp_valid && rsp_ready) begin
      for (int i = 0; i < NCH; i++) begin
        if (rsp_ch == CHW'(i) &&
            stat_done[i*STAT_W +: STAT_W] != '1)
          stat_done[i*STAT_W +: STAT_W] <=
            stat_done[i*STAT_W +: STAT_W] + STAT_W'(1);
      end
      if (rsp_dbz && stat_dbz != '1)
        stat_dbz <= stat_dbz + STAT_W'(1);
    end
  end
`endif

  udiv_laccp_q #(
    .DW(DW),
    .QI(QI),
    .QF(QF)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .start       (start && !c_busy),
    .dividend    (ca),
    .divisor     (cb),
    .busy        (c_busy),
    .valid       (c_valid),
    .div_by_zero (c_dbz),
    .q_int       (c_qi),
    .q_frac      (c_qf)
  );

endmodule

// File: tb/tb_udiv_laccp_sched.sv
// Directed bench for udiv_laccp_sched (NCH=4, DW=16, QI=16, QF=8).
// Outputs are sampled on the falling edge; inputs change there too.
module tb_udiv_laccp_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_dividend;
  logic [63:0] req_divisor;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_ch;
  logic [15:0] rsp_q_int;
  logic [7:0]  rsp_q_frac;
  logic        rsp_dbz;
  logic        sched_busy;
`ifdef UDIV_SCHED_STATS_EN
  logic [63:0] stat_done;
  logic [15:0] stat_dbz;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  udiv_laccp_sched #(
    .NCH(4), .DW(16), .QI(16), .QF(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_ch       (rsp_ch),
    .rsp_q_int    (rsp_q_int),
    .rsp_q_frac   (rsp_q_frac),
    .rsp_dbz      (rsp_dbz),
`ifdef UDIV_SCHED_STATS_EN
    .stat_done    (stat_done),
    .stat_dbz     (stat_dbz),
`endif
    .sched_busy   (sched_busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic set_req(input int ch, input int a, input int b);
    req_valid[ch]             = 1'b1;
    req_dividend[ch*16 +: 16] = 16'(a);
    req_divisor[ch*16 +: 16]  = 16'(b);
  endtask

  task automatic go();
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic wait_valid(input string tag, output int lat);
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_timeout"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic get(input string tag, input int ch, input int qi,
                     input int qf, input int dbz, output int lat);
    wait_valid(tag, lat);
    check({tag, "_ch"},   32'(rsp_ch),     32'(ch));
    check({tag, "_qi"},   32'(rsp_q_int),  32'(qi));
    check({tag, "_qf"},   32'(rsp_q_frac), 32'(qf));
    check({tag, "_dbz"},  32'(rsp_dbz),    32'(dbz));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int lat1, lat2, lat, lrel, bad, stale;
    logic [1:0]  s_ch;
    logic [15:0] s_qi;
    logic [7:0]  s_qf;

    rst          = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    rsp_ready    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_ready", 32'(req_ready),  32'hF);
    check("rst_valid", 32'(rsp_valid),  32'd0);
    check("rst_busy",  32'(sched_busy), 32'd0);
    check("rst_qi",    32'(rsp_q_int),  32'd0);

    // single request: 100/7 = 14 + 73/256
    set_req(0, 100, 7);
    go();
    check("t1_ready_low", 32'(req_ready[0]), 32'd0);
    get("t1", 0, 14, 73, 0, lat1);
    check("t1_ready_back", 32'(req_ready[0]), 32'd1);

    // divide by zero, same latency
    set_req(2, 55, 0);
    go();
    get("t2", 2, 0, 0, 1, lat2);
    check("t2_lat", 32'(lat2), 32'(lat1));

    // simultaneous requests from a fresh pointer
    do_reset();
    for (int i = 0; i < 4; i++)
      set_req(i, i + 1, 1);
    go();
    for (int i = 0; i < 4; i++)
      get($sformatf("t3_%0d", i), i, i + 1, 0, 0, lat);

    // fairness: ch0 re-requests as soon as freed, ch3 waits
    set_req(0, 10, 2);
    set_req(3, 21, 7);
    go();
    get("t4a", 0, 5, 0, 0, lat);
    set_req(0, 40, 8);
    go();
    get("t4b", 3, 3, 0, 0, lat);
    get("t4c", 0, 5, 0, 0, lat);

    // backpressure on ch1 while ch2 waits
    rsp_ready = 1'b0;
    set_req(1, 200, 10);
    set_req(2, 9, 2);
    go();
    wait_valid("t5", lat);
    check("t5_ch", 32'(rsp_ch),    32'd1);
    check("t5_qi", 32'(rsp_q_int), 32'd20);
    s_ch = rsp_ch;
    s_qi = rsp_q_int;
    s_qf = rsp_q_frac;
    bad  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_ch !== s_ch ||
          rsp_q_int !== s_qi || rsp_q_frac !== s_qf)
        bad++;
    end
    check("t5_stable",  32'(bad),          32'd0);
    check("t5_pend2",   32'(req_ready[2]), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    get("t5b", 2, 4, 128, 0, lrel);
    check("t5_relat", 32'(lrel), 32'(lat1 - 1));

    // reset in the middle of a division
    set_req(1, 8, 2);
    go();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t6_valid", 32'(rsp_valid),  32'd0);
    check("t6_ready", 32'(req_ready),  32'hF);
    check("t6_busy",  32'(sched_busy), 32'd0);
    check("t6_qi",    32'(rsp_q_int),  32'd0);
    check("t6_qf",    32'(rsp_q_frac), 32'd0);
    check("t6_ch",    32'(rsp_ch),     32'd0);
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    check("t6_stale", 32'(stale), 32'd0);
    set_req(3, 9, 3);
    go();
    get("t6b", 3, 3, 0, 0, lat);
    check("end_idle", 32'(sched_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
